// File: rtl/pending_encoder_8_3.sv
// Registered priority encoder: captures request edges into a sticky
// pending set and drains them highest-index first over valid/ready.
module pending_encoder_8_3 #(
   parameter int W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [2**W-1:0]  req,
   input  logic             ready,
   output logic [W-1:0]     code_out,
   output logic             valid,
   output logic [2**W-1:0]  pending,
   output logic             lost
);

   localparam int N = 2**W;

   logic [N-1:0] req_q, req_d;
   logic [N-1:0] pend_q, pend_d;
   logic [W-1:0] code_q, code_d;
   logic         valid_q, valid_d;
   logic         lost_q, lost_d;

   logic [N-1:0] rise;
   logic [N-1:0] clr;
   logic [W-1:0] hi;
   logic         free;
   logic         load;

   // Ascending scan so the last hit is the highest set index.
   always_comb begin
      hi = '0;
      for (int i = 0; i < N; i++) begin
         if (pend_q[i]) hi = W'(i);
      end
   end

   always_comb begin
      rise    = req & ~req_q & {N{en}};
      free    = ~valid_q | ready;
      load    = free & (|pend_q);
      clr     = '0;
      code_d  = code_q;
      valid_d = valid_q;
      req_d   = req;
      if (load) begin
         clr[hi] = 1'b1;
         code_d  = hi;
         valid_d = 1'b1;
      end else if (free) begin
         valid_d = 1'b0;
      end
      // A new edge wins over the clear, so that code is presented again.
      pend_d = (pend_q & ~clr) | rise;
      lost_d = |(rise & pend_q & ~clr);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_q   <= '0;
         pend_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         req_q   <= req_d;
         pend_q  <= pend_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         lost_q  <= lost_d;
      end
   end

   assign code_out = code_q;
   assign valid    = valid_q;
   assign pending  = pend_q;
   assign lost     = lost_q;

endmodule

// File: tb/tb_pending_encoder_8_3.sv
// Bench for pending_encoder_8_3: directed scenarios with literal
// expectations plus randomized traffic against a set-based model.
module tb_pending_encoder_8_3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       en = 1'b1;
   logic [7:0] req = '0;
   logic       ready = 1'b0;
   logic [2:0] code_out;
   logic       valid;
   logic [7:0] pending;
   logic       lost;

   int n_pass = 0;
   int n_total = 0;
   bit cmp_on = 1'b0;

   // Model state
   bit [7:0] m_prev = '0;
   bit [7:0] m_pend = '0;
   int       m_code = 0;
   bit       m_valid = 1'b0;
   bit       m_lost = 1'b0;

   pending_encoder_8_3 dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .req      (req),
      .ready    (ready),
      .code_out (code_out),
      .valid    (valid),
      .pending  (pending),
      .lost     (lost)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] got,
                      input logic [7:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
   endtask

   // Reference: pending is a set of indices; the output slot takes the
   // largest member whenever it is empty or being consumed.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_prev = '0; m_pend = '0; m_code = 0;
         m_valid = 1'b0; m_lost = 1'b0;
      end else begin
         bit [7:0] fresh;
         int top;
         bit took;
         fresh = en ? (req & ~m_prev) : 8'h00;
         took = 1'b0;
         top = -1;
         if (!m_valid || ready) begin
            for (int i = 7; i >= 0; i--)
               if (m_pend[i] && top < 0) top = i;
            if (top >= 0) begin
               m_code = top; m_valid = 1'b1; took = 1'b1;
               m_pend[top] = 1'b0;
            end else begin
               m_valid = 1'b0;
            end
         end
         m_lost = 1'b0;
         for (int i = 0; i < 8; i++) begin
            if (fresh[i]) begin
               if (m_pend[i]) m_lost = 1'b1;
               m_pend[i] = 1'b1;
            end
         end
         m_prev = req;
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("cmp_valid", {7'b0, valid}, {7'b0, m_valid});
         if (m_valid) chk("cmp_code", {5'b0, code_out}, 8'(m_code));
         chk("cmp_pending", pending, m_pend);
         chk("cmp_lost", {7'b0, lost}, {7'b0, m_lost});
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2 reset_n = 1'b0;
      #1;
      chk("rst_valid", {7'b0, valid}, 8'h00);
      chk("rst_code", {5'b0, code_out}, 8'h00);
      chk("rst_pending", pending, 8'h00);
      chk("rst_lost", {7'b0, lost}, 8'h00);
      cmp_on = 1'b1;
      tick();
      reset_n = 1'b1;
      ready = 1'b1;

      // Single request, full latency path.
      req = 8'h20;
      tick();
      chk("t1_pend", pending, 8'h20);
      chk("t1_v0", {7'b0, valid}, 8'h00);
      req = 8'h00;
      tick();
      chk("t1_v1", {7'b0, valid}, 8'h01);
      chk("t1_code", {5'b0, code_out}, 8'h05);
      chk("t1_pend0", pending, 8'h00);
      tick();
      chk("t1_vdrop", {7'b0, valid}, 8'h00);

      // Backpressure holds the presented code.
      ready = 1'b0;
      req = 8'h81;
      tick();
      req = 8'h00;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_hold_code", {5'b0, code_out}, 8'h07);
         chk("t2_hold_pend", pending, 8'h01);
      end
      ready = 1'b1;
      tick();
      chk("t2_code0", {5'b0, code_out}, 8'h00);
      chk("t2_v", {7'b0, valid}, 8'h01);
      tick();
      chk("t2_vdrop", {7'b0, valid}, 8'h00);

      // Back-to-back drain.
      req = 8'h54;
      tick();
      req = 8'h00;
      tick();
      chk("t3_c6", {4'b0, valid, code_out}, 8'h0e);
      tick();
      chk("t3_c4", {4'b0, valid, code_out}, 8'h0c);
      tick();
      chk("t3_c2", {4'b0, valid, code_out}, 8'h0a);
      tick();
      chk("t3_vdrop", {7'b0, valid}, 8'h00);

      // Lost edge on an already pending line.
      req = 8'h80;
      tick();
      req = 8'h00;
      tick();
      ready = 1'b0;
      req = 8'h08;
      tick();
      req = 8'h00;
      tick();
      req = 8'h08;
      tick();
      chk("t4_lost", {7'b0, lost}, 8'h01);
      chk("t4_pend", pending, 8'h08);
      req = 8'h00;
      tick();
      chk("t4_lost0", {7'b0, lost}, 8'h00);
      ready = 1'b1;
      tick();
      chk("t4_c3", {4'b0, valid, code_out}, 8'h0b);
      tick();
      chk("t4_done", {7'b0, valid}, 8'h00);
      chk("t4_pend0", pending, 8'h00);

      // Set-wins when an edge coincides with the load of that bit.
      req = 8'h82;
      tick();
      req = 8'h00;
      tick();
      ready = 1'b0;
      tick();
      ready = 1'b1;
      req = 8'h02;
      tick();
      chk("t5_c1a", {4'b0, valid, code_out}, 8'h09);
      chk("t5_pend", pending, 8'h02);
      chk("t5_nolost", {7'b0, lost}, 8'h00);
      req = 8'h00;
      tick();
      chk("t5_c1b", {4'b0, valid, code_out}, 8'h09);
      tick();
      chk("t5_vdrop", {7'b0, valid}, 8'h00);

      // Capture disabled.
      en = 1'b0;
      req = 8'hff;
      tick();
      req = 8'h00;
      tick();
      chk("t6_pend", pending, 8'h00);
      chk("t6_v", {7'b0, valid}, 8'h00);
      en = 1'b1;

      // Asynchronous reset mid-transfer.
      req = 8'h01;
      tick();
      req = 8'h00;
      tick();
      ready = 1'b0;
      req = 8'hf0;
      tick();
      chk("t7_pre", {valid, 3'b0, pending[7:4]}, 8'h8f);
      #3 reset_n = 1'b0;
      #1;
      chk("t7_valid", {7'b0, valid}, 8'h00);
      chk("t7_pend", pending, 8'h00);
      chk("t7_code", {5'b0, code_out}, 8'h00);
      chk("t7_lost", {7'b0, lost}, 8'h00);
      tick();
      reset_n = 1'b1;

      // Random traffic; the compare process checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         req = 8'($urandom);
         ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req = 8'h00;
      ready = 1'b1;
      repeat (12) tick();
      chk("end_pend", pending, 8'h00);
      chk("end_valid", {7'b0, valid}, 8'h00);
      cmp_on = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
